// File: rtl/sys_cntr_tx_pkg.sv
// Shared definitions for the transmit-side system controller:
// FSM state codes, source select codes and the round-robin pick.
package sys_cntr_tx_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] SEND = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic SRC_REG = 1'b0;
   localparam logic SRC_ALU = 1'b1;

   // With both slots full, serve whichever source did not go last.
   function automatic logic rr_pick(
      input logic reg_full,
      input logic alu_full,
      input logic last
   );
      if (reg_full && alu_full)
         return ~last;
      return reg_full ? SRC_REG : SRC_ALU;
   endfunction

endpackage

// File: rtl/sys_cntr_tx_slot.sv
// Single-entry holding slot: captures on strobe when empty (or being
// released), drops the strobe and flags a sticky overrun when full.
module sys_cntr_tx_slot #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         Reset,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   input  logic         rls,
   output logic [W-1:0] data,
   output logic         full,
   output logic         overrun
);

   logic [W-1:0] r_data;
   logic         r_full;
   logic         r_ovr;
   logic         w_take;

   assign w_take = in_valid & (~r_full | rls);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_data <= '0;
         r_full <= 1'b0;
         r_ovr  <= 1'b0;
      end else begin
         if (w_take) begin
            r_data <= in_data;
            r_full <= 1'b1;
         end else if (rls) begin
            r_full <= 1'b0;
         end
         if (in_valid && r_full && !rls)
            r_ovr <= 1'b1;
      end
   end

   assign data    = r_data;
   assign full    = r_full;
   assign overrun = r_ovr;

endmodule

// File: rtl/sys_cntr_tx.sv
// Transmit-side controller: arbitrates REG/ALU slots and serialises
// them byte by byte (LSB first) into UART_TX with a valid/busy handshake.
module sys_cntr_tx
   import sys_cntr_tx_pkg::*;
#(
   parameter int width     = 8,
   parameter int ALU_BYTES = 2
) (
   input  logic                       CLK,
   input  logic                       Reset,
   input  logic [width-1:0]           RdData,
   input  logic                       RdData_Valid,
   input  logic [ALU_BYTES*width-1:0] ALU_OUT,
   input  logic                       ALU_OUT_Valid,
   input  logic                       Tx_Busy,
   output logic [width-1:0]           Tx_P_Data,
   output logic                       Tx_Valid,
   output logic                       Busy,
   output logic                       Overrun
);

   localparam int IW = (ALU_BYTES > 1) ? $clog2(ALU_BYTES) : 1;
   localparam int AW = ALU_BYTES * width;

   logic [1:0]       r_state;
   logic             r_src;
   logic             r_last;
   logic [IW-1:0]    r_idx;
   logic [width-1:0] r_data;
   logic             r_valid;

   logic [width-1:0] w_reg_data;
   logic [AW-1:0]    w_alu_data;
   logic             w_reg_full;
   logic             w_alu_full;
   logic             w_reg_ovr;
   logic             w_alu_ovr;
   logic             w_go;
   logic             w_pick;
   logic             w_last_byte;
   logic             w_fin;
   logic             w_rel_reg;
   logic             w_rel_alu;
   logic [width-1:0] w_byte;

   sys_cntr_tx_slot #(.W(width)) u_reg (
      .CLK      (CLK),
      .Reset    (Reset),
      .in_data  (RdData),
      .in_valid (RdData_Valid),
      .rls      (w_rel_reg),
      .data     (w_reg_data),
      .full     (w_reg_full),
      .overrun  (w_reg_ovr)
   );

   sys_cntr_tx_slot #(.W(AW)) u_alu (
      .CLK      (CLK),
      .Reset    (Reset),
      .in_data  (ALU_OUT),
      .in_valid (ALU_OUT_Valid),
      .rls      (w_rel_alu),
      .data     (w_alu_data),
      .full     (w_alu_full),
      .overrun  (w_alu_ovr)
   );

   assign w_go = (r_state == IDLE) & ~Tx_Busy & (w_reg_full | w_alu_full);
   assign w_pick = rr_pick(w_reg_full, w_alu_full, r_last);
   assign w_last_byte = (r_src == SRC_REG) | (r_idx == IW'(ALU_BYTES - 1));
   assign w_fin = (r_state == DONE) & ~Tx_Busy & w_last_byte;
   assign w_rel_reg = w_fin & (r_src == SRC_REG);
   assign w_rel_alu = w_fin & (r_src == SRC_ALU);
   assign w_byte = (r_src == SRC_REG) ? w_reg_data
                 : w_alu_data[int'(r_idx)*width +: width];

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
         r_src   <= SRC_REG;
         r_last  <= SRC_ALU;
         r_idx   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: if (w_go) begin
               r_src   <= w_pick;
               r_last  <= w_pick;
               r_idx   <= '0;
               r_state <= LOAD;
            end
            LOAD: begin
               r_data  <= w_byte;
               r_valid <= 1'b1;
               r_state <= SEND;
            end
            SEND: if (Tx_Busy) begin
               r_valid <= 1'b0;
               r_state <= DONE;
            end
            DONE: if (!Tx_Busy) begin
               if (w_last_byte) begin
                  r_state <= IDLE;
               end else begin
                  r_idx   <= r_idx + IW'(1);
                  r_state <= LOAD;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign Tx_P_Data = r_data;
   assign Tx_Valid  = r_valid;
   assign Busy      = w_reg_full | w_alu_full | (r_state != IDLE);
   assign Overrun   = w_reg_ovr | w_alu_ovr;

endmodule

// File: tb/tb_sys_cntr_tx.sv
// Bench for sys_cntr_tx: UART responder, transaction-level byte-order
// model, per-cycle Busy/Overrun/hold checks and directed scenarios.
module tb_sys_cntr_tx;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [7:0]  RdData;
   logic        RdData_Valid;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_Valid;
   logic        Tx_Busy;
   logic [7:0]  Tx_P_Data;
   logic        Tx_Valid;
   logic        Busy;
   logic        Overrun;

   logic uart_busy  = 1'b0;
   logic force_busy = 1'b0;
   assign Tx_Busy = uart_busy | force_busy;

   sys_cntr_tx #(.width(8), .ALU_BYTES(2)) dut (
      .CLK           (CLK),
      .Reset         (Reset),
      .RdData        (RdData),
      .RdData_Valid  (RdData_Valid),
      .ALU_OUT       (ALU_OUT),
      .ALU_OUT_Valid (ALU_OUT_Valid),
      .Tx_Busy       (Tx_Busy),
      .Tx_P_Data     (Tx_P_Data),
      .Tx_Valid      (Tx_Valid),
      .Busy          (Busy),
      .Overrun       (Overrun)
   );

   always #5 CLK = ~CLK;

   // reference model state
   logic [7:0] exp_q[$];
   logic [7:0] log_b[$];
   int   pending = 0;
   logic m_ovr   = 1'b0;
   logic m_last  = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   rises = 0;
   int   accepts = 0;
   int   epoch = 0;
   bit   chk_on = 1'b0;
   bit   uart_rand = 1'b0;
   int   uart_delay = 0;
   int   uart_dur = 2;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // UART_TX responder
   initial begin
      int ep;
      int d;
      int du;
      forever begin
         @(negedge CLK);
         if (!Reset && Tx_Valid) begin
            ep = epoch;
            accepts++;
            log_b.push_back(Tx_P_Data);
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_byte actual=%0h required=none",
                        Tx_P_Data);
            end else begin
               if (Tx_P_Data !== exp_q[0]) begin
                  bad++;
                  $display("FAIL byte_order actual=%0h required=%0h",
                           Tx_P_Data, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
            d  = uart_rand ? $urandom_range(0, 3) : uart_delay;
            du = uart_rand ? $urandom_range(1, 5) : uart_dur;
            for (int i = 0; i < d; i++)
               if (ep == epoch) @(negedge CLK);
            if (ep == epoch) begin
               uart_busy = 1'b1;
               for (int i = 0; i < du; i++)
                  if (ep == epoch) @(negedge CLK);
               uart_busy = 1'b0;
               if (ep == epoch) begin
                  @(posedge CLK);
                  if (ep == epoch && pending > 0) pending--;
               end
            end
            uart_busy = 1'b0;
         end
      end
   end

   // per-cycle compare
   initial begin
      logic       pv;
      logic [7:0] pd;
      pv = 1'b0;
      pd = 8'h00;
      forever begin
         @(negedge CLK);
         if (!Reset && chk_on) begin
            chk("busy", Busy, (pending > 0) ? 1 : 0);
            chk("overrun", Overrun, m_ovr);
            if (pv && Tx_Valid) chk("data_hold", Tx_P_Data, pd);
         end
         if (Tx_Valid && !pv) rises++;
         pv = Tx_Valid;
         pd = Tx_P_Data;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic do_reset();
      @(negedge CLK);
      #2;
      Reset = 1'b1;
      epoch++;
      uart_busy = 1'b0;
      exp_q.delete();
      pending = 0;
      m_ovr   = 1'b0;
      m_last  = 1'b1;
      #1;
      chk("rst_tx_valid", Tx_Valid, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_overrun", Overrun, 0);
      @(negedge CLK);
      Reset = 1'b0;
   endtask

   task automatic burst(input bit dr, input bit da, input logic [7:0] rd,
                        input logic [15:0] al, input int extra,
                        input logic [15:0] xd);
      @(negedge CLK);
      RdData        = rd;
      RdData_Valid  = dr;
      ALU_OUT       = al;
      ALU_OUT_Valid = da;
      @(posedge CLK);
      if (dr && da) begin
         if (m_last) begin
            exp_q.push_back(rd);
            exp_q.push_back(al[7:0]);
            exp_q.push_back(al[15:8]);
         end else begin
            exp_q.push_back(al[7:0]);
            exp_q.push_back(al[15:8]);
            exp_q.push_back(rd);
            m_last = 1'b0;
         end
      end else if (dr) begin
         exp_q.push_back(rd);
         m_last = 1'b0;
      end else if (da) begin
         exp_q.push_back(al[7:0]);
         exp_q.push_back(al[15:8]);
         m_last = 1'b1;
      end
      pending += (dr ? 1 : 0) + (da ? 2 : 0);
      @(negedge CLK);
      RdData_Valid  = 1'b0;
      ALU_OUT_Valid = 1'b0;
      if (extra != 0) begin
         RdData        = xd[7:0];
         ALU_OUT       = xd;
         RdData_Valid  = (extra == 1);
         ALU_OUT_Valid = (extra == 2);
         @(posedge CLK);
         m_ovr = 1'b1;
         @(negedge CLK);
         RdData_Valid  = 1'b0;
         ALU_OUT_Valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (Busy && n < 2000);
      chk({nm, "_idle"}, Busy, 0);
      chk({nm, "_queue_empty"}, exp_q.size(), 0);
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      int lat;
      int n0;
      int r0;
      int w;
      Reset         = 1'b1;
      RdData        = 8'h00;
      RdData_Valid  = 1'b0;
      ALU_OUT       = 16'h0000;
      ALU_OUT_Valid = 1'b0;
      #3;
      chk("init_tx_valid", Tx_Valid, 0);
      chk("init_tx_data", Tx_P_Data, 0);
      chk("init_busy", Busy, 0);
      chk("init_overrun", Overrun, 0);
      @(negedge CLK);
      Reset  = 1'b0;
      chk_on = 1'b1;

      // 1: single REG byte, slow UART
      uart_delay = 10;
      uart_dur   = 3;
      n0 = log_b.size();
      @(negedge CLK);
      RdData       = 8'h5A;
      RdData_Valid = 1'b1;
      @(posedge CLK);
      exp_q.push_back(8'h5A);
      pending++;
      m_last = 1'b0;
      lat = 1;
      @(negedge CLK);
      RdData_Valid = 1'b0;
      while (!Tx_Valid && lat < 20) begin
         @(posedge CLK);
         lat++;
         @(negedge CLK);
      end
      chk("t1_latency", lat, 3);
      w = 0;
      do begin
         @(posedge CLK);
         w++;
      end while (!Tx_Busy && w < 50);
      @(negedge CLK);
      chk("t1_valid_drop", Tx_Valid, 0);
      chk("t1_busy_held", Busy, 1);
      w = 0;
      do begin
         @(posedge CLK);
         w++;
      end while (Tx_Busy && w < 50);
      @(negedge CLK);
      chk("t1_busy_drop", Busy, 0);
      wait_idle("t1");
      chk("t1_count", log_b.size() - n0, 1);
      if (log_b.size() > n0) chk("t1_byte", log_b[n0], 8'h5A);

      // 2: ALU word, LSB first
      uart_delay = 1;
      uart_dur   = 2;
      n0 = log_b.size();
      r0 = rises;
      burst(1'b0, 1'b1, 8'h00, 16'hBEEF, 0, 16'h0);
      wait_idle("t2");
      chk("t2_count", log_b.size() - n0, 2);
      chk("t2_pulses", rises - r0, 2);
      if (log_b.size() >= n0 + 2) begin
         chk("t2_byte0", log_b[n0], 8'hEF);
         chk("t2_byte1", log_b[n0+1], 8'hBE);
      end

      // 3: simultaneous strobes and round-robin
      do_reset();
      n0 = log_b.size();
      burst(1'b1, 1'b1, 8'h11, 16'h2233, 0, 16'h0);
      wait_idle("t3a");
      burst(1'b1, 1'b0, 8'h44, 16'h0, 0, 16'h0);
      wait_idle("t3b");
      burst(1'b1, 1'b1, 8'h11, 16'h2233, 0, 16'h0);
      wait_idle("t3c");
      chk("t3_count", log_b.size() - n0, 7);
      if (log_b.size() >= n0 + 7) begin
         chk("t3_a0", log_b[n0],   8'h11);
         chk("t3_a1", log_b[n0+1], 8'h33);
         chk("t3_a2", log_b[n0+2], 8'h22);
         chk("t3_c0", log_b[n0+4], 8'h33);
         chk("t3_c1", log_b[n0+5], 8'h22);
         chk("t3_c2", log_b[n0+6], 8'h11);
      end

      // 4: overrun on full REG slot
      n0 = log_b.size();
      burst(1'b1, 1'b0, 8'h66, 16'h0, 1, 16'h0077);
      wait_idle("t4");
      chk("t4_count", log_b.size() - n0, 1);
      if (log_b.size() > n0) chk("t4_byte", log_b[n0], 8'h66);
      chk("t4_overrun", Overrun, 1);

      // 6: Tx_Busy already high before strobe
      n0 = log_b.size();
      force_busy = 1'b1;
      burst(1'b1, 1'b0, 8'h3C, 16'h0, 0, 16'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         chk("t6_hold_off", Tx_Valid, 0);
      end
      force_busy = 1'b0;
      wait_idle("t6");
      chk("t6_count", log_b.size() - n0, 1);
      if (log_b.size() > n0) chk("t6_byte", log_b[n0], 8'h3C);
      chk("t6_overrun_sticky", Overrun, 1);

      // 5: reset during SEND
      uart_delay = 10;
      burst(1'b0, 1'b1, 8'h00, 16'hCAFE, 0, 16'h0);
      w = 0;
      while (!Tx_Valid && w < 20) begin
         @(negedge CLK);
         w++;
      end
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("t5_pre_valid", Tx_Valid, 1);
      chk("t5_pre_overrun", Overrun, 1);
      n0 = log_b.size();
      do_reset();
      repeat (30) @(negedge CLK);
      chk("t5_nothing_sent", log_b.size() - n0, 0);
      chk("t5_idle", Busy, 0);

      // randomized bursts
      uart_rand = 1'b1;
      for (int k = 0; k < 40; k++) begin
         int md;
         int ex;
         md = $urandom_range(1, 3);
         ex = 0;
         if ($urandom_range(0, 7) == 0) ex = (md == 2) ? 2 : 1;
         burst(md != 2, md != 1, 8'($urandom), 16'($urandom), ex,
               16'($urandom));
         wait_idle("rnd");
      end

      chk("pulses_vs_frames", rises, accepts);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
